// File: rtl/loa_pkg.sv
// Shared definitions for the LOA subtractor datapath: widths, FSM encoding
// and the legal APPROX_BITS check.
package loa_pkg;

  localparam int DATA_W  = 32;
  localparam int CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit isLegalApprox(input int bits);
    return (bits == 0) || (bits == 8) || (bits == 16) || (bits == 24);
  endfunction

endpackage

// File: rtl/rca_8bits.sv
// Plain 8-bit ripple-carry adder, shared by every exact chunk of the subtractor.
module rca_8bits
  import loa_pkg::*;
(
  input  logic [CHUNK_W-1:0] i_a,
  input  logic [CHUNK_W-1:0] i_b,
  input  logic               i_cin,
  output logic [CHUNK_W-1:0] o_sum,
  output logic               o_cout
);

  always_comb begin
    logic c;
    o_sum = '0;
    c     = i_cin;
    for (int i = 0; i < CHUNK_W; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ c;
      c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout = c;
  end

endmodule

// File: rtl/loa_sub_32bits_seq.sv
// Sequential 32-bit approximate subtractor: lower-part-OR for the low bits,
// exact upper bits one 8-bit chunk per cycle through a single shared adder.
module loa_sub_32bits_seq
  import loa_pkg::*;
#(
  parameter int APPROX_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              borrow
);

  if (!isLegalApprox(APPROX_BITS)) begin : g_badApprox
    $error("loa_sub_32bits_seq: APPROX_BITS must be 0, 8, 16 or 24");
  end

  localparam logic [1:0] START_K = 2'(APPROX_BITS / CHUNK_W);
  localparam int CARRY_IDX = (APPROX_BITS == 0) ? 0 : APPROX_BITS - 1;
  localparam logic [DATA_W-1:0] LOW_MASK =
    (APPROX_BITS == 0) ? '0 : DATA_W'((64'd1 << APPROX_BITS) - 64'd1);

  state_t r_state;
  state_t w_nextState;

  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_bn;
  logic [DATA_W-1:0]  r_diff;
  logic               r_borrow;
  logic               r_carry;
  logic [1:0]         r_k;

  logic [4:0]         w_base;
  logic [CHUNK_W-1:0] w_aChunk;
  logic [CHUNK_W-1:0] w_bChunk;
  logic [CHUNK_W-1:0] w_sum;
  logic               w_cout;
  logic               w_loaCarry;

  // Exact mode injects the +1 of two's complement; approximate mode replaces it
  // with the carry generated by the top approximated bit.
  assign w_loaCarry = (APPROX_BITS == 0) ? 1'b1 : (a[CARRY_IDX] & ~b[CARRY_IDX]);

  assign w_base   = {r_k, 3'b000};
  assign w_aChunk = r_a[w_base +: CHUNK_W];
  assign w_bChunk = r_bn[w_base +: CHUNK_W];

  rca_8bits u_rca (
    .i_a    (w_aChunk),
    .i_b    (w_bChunk),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_nextState = CALC;
      CALC:    if (r_k == 2'd3) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_bn     <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_carry  <= 1'b0;
      r_k      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_bn    <= ~b;
            r_diff  <= (a | ~b) & LOW_MASK;
            r_carry <= w_loaCarry;
            r_k     <= START_K;
          end
        end
        CALC: begin
          r_diff[w_base +: CHUNK_W] <= w_sum;
          r_carry                   <= w_cout;
          r_k                       <= r_k + 2'd1;
          if (r_k == 2'd3) r_borrow <= ~w_cout;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;

endmodule

// File: tb/tb_loa_sub_32bits_seq.sv
// Directed bench for loa_sub_32bits_seq with one instance per APPROX_BITS
// setting (0, 8, 24), hand-computed expected results.
module tb_loa_sub_32bits_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid  [3];
  logic        inReady  [3];
  logic [31:0] aIn      [3];
  logic [31:0] bIn      [3];
  logic        outValid [3];
  logic        outReady [3];
  logic [31:0] diffOut  [3];
  logic        borrowOut[3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  loa_sub_32bits_seq #(.APPROX_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(aIn[0]), .b(bIn[0]), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .diff(diffOut[0]), .borrow(borrowOut[0])
  );

  loa_sub_32bits_seq #(.APPROX_BITS(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(aIn[1]), .b(bIn[1]), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .diff(diffOut[1]), .borrow(borrowOut[1])
  );

  loa_sub_32bits_seq #(.APPROX_BITS(24)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(aIn[2]), .b(bIn[2]), .out_valid(outValid[2]), .out_ready(outReady[2]),
    .diff(diffOut[2]), .borrow(borrowOut[2])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction: accept, wait for result, optional stall with
  // stray in_valid requests, then the output handshake.
  task automatic applyStimulus(input int d, input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] expDiff, input logic expBorrow,
                               input int expLat, input int stall, input string tag);
    int waitCnt = 0;
    int lat = 0;
    while (!inReady[d] && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput({tag, ".readyBefore"}, 32'(inReady[d]), 32'd1);
    inValid[d] = 1'b1;
    aIn[d] = av;
    bIn[d] = bv;
    @(posedge clk); #1;
    inValid[d] = 1'b0;
    aIn[d] = 32'hDEADBEEF;
    bIn[d] = 32'h13579BDF;
    checkOutput({tag, ".readyBusy"}, 32'(inReady[d]), 32'd0);
    while (!outValid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".diff"}, diffOut[d], expDiff);
    checkOutput({tag, ".borrow"}, 32'(borrowOut[d]), 32'(expBorrow));
    for (int i = 0; i < stall; i++) begin
      inValid[d] = 1'b1;
      aIn[d] = 32'hA5A50000 + 32'(i);
      bIn[d] = 32'h00000001;
      @(posedge clk); #1;
      checkOutput({tag, ".stallValid"}, 32'(outValid[d]), 32'd1);
      checkOutput({tag, ".stallDiff"}, diffOut[d], expDiff);
      checkOutput({tag, ".stallReady"}, 32'(inReady[d]), 32'd0);
    end
    inValid[d] = 1'b0;
    outReady[d] = 1'b1;
    @(posedge clk); #1;
    outReady[d] = 1'b0;
    checkOutput({tag, ".validDrop"}, 32'(outValid[d]), 32'd0);
    checkOutput({tag, ".readyRise"}, 32'(inReady[d]), 32'd1);
    checkOutput({tag, ".diffHeld"}, diffOut[d], expDiff);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seenValid;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      inValid[i] = 1'b0;
      outReady[i] = 1'b0;
      aIn[i] = '0;
      bIn[i] = '0;
    end
    // in_valid held during reset must not start a transaction
    inValid[0] = 1'b1;
    aIn[0] = 32'h00000100;
    bIn[0] = 32'h00000001;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    inValid[0] = 1'b0;

    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset%0d.inReady", i), 32'(inReady[i]), 32'd1);
      checkOutput($sformatf("reset%0d.outValid", i), 32'(outValid[i]), 32'd0);
      checkOutput($sformatf("reset%0d.diff", i), diffOut[i], 32'd0);
      checkOutput($sformatf("reset%0d.borrow", i), 32'(borrowOut[i]), 32'd0);
    end

    applyStimulus(0, 32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 4, 0, "ex.basic");
    applyStimulus(0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 4, 0, "ex.wrap");
    applyStimulus(0, 32'h12345678, 32'h02000000, 32'h10345678, 1'b0, 4, 1, "ex.mixed");

    applyStimulus(1, 32'h00000100, 32'h00000001, 32'h000000FE, 1'b0, 3, 0, "a8.basic");
    applyStimulus(1, 32'h00000080, 32'h00000000, 32'h000000FF, 1'b0, 3, 0, "a8.loaCarry");
    applyStimulus(1, 32'h00000005, 32'h00000007, 32'hFFFFFFFD, 1'b1, 3, 0, "a8.borrow");

    applyStimulus(2, 32'h12345678, 32'h02000000, 32'h0FFFFFFF, 1'b0, 1, 5, "a24.stall");
    applyStimulus(2, 32'h00800000, 32'h00000000, 32'h00FFFFFF, 1'b0, 1, 0, "a24.loaCarry");

    // Abort a transaction with reset during its second CALC cycle
    inValid[0] = 1'b1;
    aIn[0] = 32'hFFFFFFFF;
    bIn[0] = 32'h00000001;
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort.inReady", 32'(inReady[0]), 32'd1);
    checkOutput("abort.outValid", 32'(outValid[0]), 32'd0);
    checkOutput("abort.diff", diffOut[0], 32'd0);
    checkOutput("abort.borrow", 32'(borrowOut[0]), 32'd0);
    seenValid = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (outValid[0]) seenValid++;
    end
    checkOutput("abort.noPulse", 32'(seenValid), 32'd0);
    applyStimulus(0, 32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 4, 0, "abort.recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
